// File: rtl/vga_ctrl_regs_if.sv
// CPU I/O bus between the host and the VGA control register file.
// The master drives address, select, strobe and write data; the slave
// returns read data and the enable for the external bus buffer.
interface vga_ctrl_regs_if #(
    parameter int DATA_W = 8
);
    logic [3:0]        addr;
    logic              _vga_io;
    logic              _wr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_oe;

    modport master (
        output addr, _vga_io, _wr, data_in,
        input  data_out, data_oe
    );

    modport slave (
        input  addr, _vga_io, _wr, data_in,
        output data_out, data_oe
    );
endinterface

// File: rtl/vga_ctrl_regs.sv
// VGA control register file: mode/plane/IRQ enables, background colour
// bank, vsync/hsync synchronizers and a sticky W1C interrupt block.
// Optional feature macro: VGA_LINE_IRQ_EN adds the raster line counter,
// the LCMP/LCNT registers and the line-compare interrupt. Without it,
// addresses 2..5 read 0 and only vsync can raise irq.
module vga_ctrl_regs #(
    parameter int DATA_W   = 8,
    parameter int BG_SEL_W = 2,
    parameter int LINE_W   = 10
) (
    input  logic                clk,
    input  logic                reset,
    vga_ctrl_regs_if.slave      bus,
    input  logic                vsync,
    input  logic                hsync,
    input  logic                _char_bg,
    input  logic [BG_SEL_W-1:0] bg_sel,
    output logic [DATA_W-1:0]   dcol,
    output logic                dcol_oe,
    output logic [1:0]          mode,
    output logic                plane,
    output logic                irq
);
    localparam int NBG  = 2 ** BG_SEL_W;
    localparam int HI_W = LINE_W - 8;

    localparam logic [3:0] A_CTRL    = 4'd0;
    localparam logic [3:0] A_STATUS  = 4'd1;
    localparam logic [3:0] A_LCMP_LO = 4'd2;
    localparam logic [3:0] A_LCMP_HI = 4'd3;
    localparam logic [3:0] A_LCNT_LO = 4'd4;
    localparam logic [3:0] A_LCNT_HI = 4'd5;

    // ---------------------------------------------------------------
    // Bus write strobe: one commit per access, on its first cycle.
    // ---------------------------------------------------------------
    logic wr_now, wr_prev, wr_stb;
    assign wr_now = ~bus._vga_io & ~bus._wr;

    // Remember last cycle's write sample; it follows the pins during reset
    // too, so a strobe held low across reset is not taken as a new access.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking (<=) so every flop samples
        // the pre-edge values; blocking (=) here would create order races.
        wr_prev <= wr_now;
    end

    assign wr_stb = wr_now & ~wr_prev & ~reset;

    logic                bg_hit;
    logic [BG_SEL_W-1:0] bg_idx;
    assign bg_hit = bus.addr[3] && ({1'b0, bus.addr[2:0]} < 4'(NBG));
    assign bg_idx = bus.addr[BG_SEL_W-1:0];

    logic ctrl_wr, status_wr;
    assign ctrl_wr   = wr_stb && (bus.addr == A_CTRL);
    assign status_wr = wr_stb && (bus.addr == A_STATUS);

    // ---------------------------------------------------------------
    // Sync path: 2-flop synchronizers plus registered falling-edge detect.
    // ---------------------------------------------------------------
    logic [1:0] vs_pipe, hs_pipe;
    logic       vs_dly, vs_fall;
    logic       vsync_s, hsync_s;
    assign vsync_s = vs_pipe[1];
    assign hsync_s = hs_pipe[1];

    // Synchronize vsync/hsync and detect vsync falling edges; cleared to 0 so
    // an idle-high pin only produces a rising edge after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            vs_pipe <= '0;
            hs_pipe <= '0;
            vs_dly  <= 1'b0;
            vs_fall <= 1'b0;
        end else begin
            vs_pipe <= {vs_pipe[0], vsync};
            hs_pipe <= {hs_pipe[0], hsync};
            vs_dly  <= vs_pipe[1];
            vs_fall <= vs_dly & ~vs_pipe[1];
        end
    end

    // ---------------------------------------------------------------
    // CTRL fields and vsync pending bit.
    // ---------------------------------------------------------------
    logic vs_en, vs_pend;
    logic ln_en, ln_pend;

    // CTRL register and vsync sticky pending; a set beats a same-cycle W1C.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode    <= 2'd0;
            plane   <= 1'b0;
            vs_en   <= 1'b0;
            vs_pend <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                mode  <= bus.data_in[1:0];
                plane <= bus.data_in[2];
                vs_en <= bus.data_in[3];
            end
            vs_pend <= (vs_pend & ~(status_wr & bus.data_in[0])) | vs_fall;
        end
    end

`ifdef VGA_LINE_IRQ_EN
    // ---------------------------------------------------------------
    // Raster line counter and line-compare interrupt.
    // ---------------------------------------------------------------
    logic              hs_dly, hs_fall;
    logic [LINE_W-1:0] lcnt, lcnt_nxt, lcmp;
    logic              lcnt_ld, ln_set;

    // hsync falling-edge detect, aligned with vs_fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_dly  <= 1'b0;
            hs_fall <= 1'b0;
        end else begin
            hs_dly  <= hs_pipe[1];
            hs_fall <= hs_dly & ~hs_pipe[1];
        end
    end

    // Next counter value: vsync clear wins over hsync, count saturates.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        lcnt_nxt = lcnt;
        lcnt_ld  = 1'b0;
        if (vs_fall) begin
            lcnt_nxt = '0;
            lcnt_ld  = 1'b1;
        end else if (hs_fall && (lcnt != '1)) begin
            lcnt_nxt = lcnt + LINE_W'(1);
            lcnt_ld  = 1'b1;
        end
    end

    assign ln_set = lcnt_ld && (lcnt_nxt == lcmp);

    // Line counter, compare register, ln_en and the line pending bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            lcnt    <= '0;
            lcmp    <= '0;
            ln_en   <= 1'b0;
            ln_pend <= 1'b0;
        end else begin
            lcnt <= lcnt_nxt;
            if (wr_stb && (bus.addr == A_LCMP_LO))
                lcmp[7:0] <= bus.data_in[7:0];
            if (wr_stb && (bus.addr == A_LCMP_HI))
                lcmp[LINE_W-1:8] <= bus.data_in[HI_W-1:0];
            if (ctrl_wr)
                ln_en <= bus.data_in[4];
            ln_pend <= (ln_pend & ~(status_wr & bus.data_in[1])) | ln_set;
        end
    end

    assign irq = (vs_pend & vs_en) | (ln_pend & ln_en);
`else
    assign ln_en   = 1'b0;
    assign ln_pend = 1'b0;
    assign irq     = vs_pend & vs_en;
`endif

    // ---------------------------------------------------------------
    // Background colour bank and registered colour output stage.
    // ---------------------------------------------------------------
    logic [DATA_W-1:0] bgcol [NBG];

    // Colour bank writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the bank is small and must read 0 after reset, so it is
            // built from resettable flops rather than a RAM macro.
            for (int i = 0; i < NBG; i++)
                bgcol[i] <= '0;
        end else if (wr_stb && bg_hit) begin
            bgcol[bg_idx] <= bus.data_in;
        end
    end

    // One-cycle colour stage toward the pixel mux.
    always_ff @(posedge clk) begin
        if (reset) begin
            dcol    <= '0;
            dcol_oe <= 1'b0;
        end else begin
            dcol    <= (~_char_bg) ? bgcol[bg_sel] : '0;
            dcol_oe <= ~_char_bg;
        end
    end

    // ---------------------------------------------------------------
    // Read path.
    // ---------------------------------------------------------------
    assign bus.data_oe = ~bus._vga_io & bus._wr;

    // Combinational read mux; unmapped addresses and unused high bits read 0.
    always_comb begin
        bus.data_out = '0;
        case (bus.addr)
            A_CTRL:    bus.data_out[6:0] = {hsync_s, vsync_s, ln_en, vs_en, plane, mode};
            A_STATUS:  bus.data_out[1:0] = {ln_pend, vs_pend};
`ifdef VGA_LINE_IRQ_EN
            A_LCMP_LO: bus.data_out[7:0] = lcmp[7:0];
            A_LCMP_HI: bus.data_out[HI_W-1:0] = lcmp[LINE_W-1:8];
            A_LCNT_LO: bus.data_out[7:0] = lcnt[7:0];
            A_LCNT_HI: bus.data_out[HI_W-1:0] = lcnt[LINE_W-1:8];
`endif
            default:   if (bg_hit) bus.data_out = bgcol[bg_idx];
        endcase
    end
endmodule

// File: tb/tb_vga_ctrl_regs.sv
// Self-checking bench for vga_ctrl_regs. Expected values are pushed to a
// scoreboard queue when stimulus is driven and popped when the DUT output
// is sampled. Covers both builds (with and without VGA_LINE_IRQ_EN).
module tb_vga_ctrl_regs;
    localparam int DATA_W   = 8;
    localparam int BG_SEL_W = 2;
    localparam int LINE_W   = 10;

`ifdef VGA_LINE_IRQ_EN
    localparam logic [7:0] CTRL_MASK = 8'h1F;
`else
    localparam logic [7:0] CTRL_MASK = 8'h0F;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                vsync, hsync, _char_bg;
    logic [BG_SEL_W-1:0] bg_sel;
    logic [DATA_W-1:0]   dcol;
    logic                dcol_oe;
    logic [1:0]          mode;
    logic                plane;
    logic                irq;

    vga_ctrl_regs_if #(.DATA_W(DATA_W)) bus ();

    vga_ctrl_regs #(
        .DATA_W  (DATA_W),
        .BG_SEL_W(BG_SEL_W),
        .LINE_W  (LINE_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .vsync   (vsync),
        .hsync   (hsync),
        ._char_bg(_char_bg),
        .bg_sel  (bg_sel),
        .dcol    (dcol),
        .dcol_oe (dcol_oe),
        .mode    (mode),
        .plane   (plane),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", sb.size(), 1);
        end else begin
            e = sb.pop_front();
            check(e.tag, obs, e.val);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        bus.addr    = a;
        bus.data_in = d;
        bus._vga_io = 1'b0;
        bus._wr     = 1'b0;
        tick();
        bus._vga_io = 1'b1;
        bus._wr     = 1'b1;
        tick();
    endtask

    task automatic bus_read(input logic [3:0] a, input string tag, input logic [31:0] exp);
        bus.addr    = a;
        bus._vga_io = 1'b0;
        bus._wr     = 1'b1;
        push(tag, exp);
        #1;
        pop_check(bus.data_out);
        check({tag, "_oe"}, bus.data_oe, 1);
        bus._vga_io = 1'b1;
    endtask

    task automatic hs_pulse();
        hsync = 1'b0;
        tick(3);
        hsync = 1'b1;
        tick(3);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_cnt;

        bus.addr    = 4'd0;
        bus.data_in = '0;
        bus._vga_io = 1'b1;
        bus._wr     = 1'b1;
        vsync       = 1'b1;
        hsync       = 1'b1;
        _char_bg    = 1'b1;
        bg_sel      = '0;
        reset       = 1'b1;

        // Reset state after one clock with reset high.
        tick();
        push("rst_mode", 0);    pop_check(mode);
        push("rst_plane", 0);   pop_check(plane);
        push("rst_irq", 0);     pop_check(irq);
        push("rst_dcol", 0);    pop_check(dcol);
        push("rst_dcol_oe", 0); pop_check(dcol_oe);
        push("rst_data_oe", 0); pop_check(bus.data_oe);
        bus_read(4'd0, "rst_ctrl", 0);
        reset = 1'b0;
        tick(3);
        bus_read(4'd1, "rst_status", 0);
        for (int i = 0; i < 4; i++)
            bus_read(4'(8 + i), $sformatf("rst_bgcol%0d", i), 0);
`ifdef VGA_LINE_IRQ_EN
        bus_read(4'd2, "rst_lcmp_lo", 0);
        bus_read(4'd4, "rst_lcnt_lo", 0);
`endif

        // Write strobe held across a reset must not commit afterwards.
        bus.addr    = 4'd8;
        bus.data_in = 8'h55;
        bus._vga_io = 1'b0;
        bus._wr     = 1'b0;
        reset       = 1'b1;
        tick();
        reset = 1'b0;
        tick(2);
        bus.data_in = 8'h66;
        tick();
        bus._vga_io = 1'b1;
        bus._wr     = 1'b1;
        tick();
        bus_read(4'd8, "rst_abort_bg0", 0);

        // CTRL write held for 5 clocks: only the first cycle commits.
        bus.addr    = 4'd0;
        bus.data_in = 8'h1B;
        bus._vga_io = 1'b0;
        bus._wr     = 1'b0;
        push("ctrl_mode_edge", 3);
        tick();
        pop_check(mode);
        bus.data_in = 8'h04;
        tick(4);
        bus._vga_io = 1'b1;
        bus._wr     = 1'b1;
        tick();
        push("ctrl_plane_once", 0); pop_check(plane);
        push("ctrl_mode_once", 3);  pop_check(mode);
        bus_read(4'd0, "ctrl_read", (8'h1B & CTRL_MASK) | 8'h60);

        // Unmapped addresses.
        bus_write(4'd12, 8'h99);
        bus_read(4'd12, "unmapped_12", 0);
        bus_read(4'd7, "unmapped_7", 0);

        // vsync interrupt: irq 4 clocks after the raw falling edge.
        bus_write(4'd0, 8'h08);
        vsync = 1'b0;
        tick(3);
        push("vs_irq_early", 0); pop_check(irq);
        tick();
        push("vs_irq", 1); pop_check(irq);
`ifdef VGA_LINE_IRQ_EN
        bus_read(4'd1, "vs_status", 8'h03);
`else
        bus_read(4'd1, "vs_status", 8'h01);
`endif
        vsync = 1'b1;
        tick(4);
        bus_write(4'd1, 8'h01);
        push("vs_w1c_irq", 0); pop_check(irq);
`ifdef VGA_LINE_IRQ_EN
        bus_read(4'd1, "vs_w1c_status", 8'h02);
`else
        bus_read(4'd1, "vs_w1c_status", 8'h00);
`endif

        // Re-arm vs_pend, then W1C lands on the same edge as a new vs_fall.
        vsync = 1'b0;
        tick(4);
        vsync = 1'b1;
        tick(4);
        vsync = 1'b0;
        tick(3);
        bus.addr    = 4'd1;
        bus.data_in = 8'h01;
        bus._vga_io = 1'b0;
        bus._wr     = 1'b0;
        tick();
        bus._vga_io = 1'b1;
        bus._wr     = 1'b1;
        tick();
        push("vs_set_wins_irq", 1); pop_check(irq);
        bus.addr = 4'd1;
        bus._vga_io = 1'b0;
        push("vs_set_wins_pend", 1);
        #1;
        pop_check(32'(bus.data_out[0]));
        bus._vga_io = 1'b1;
        vsync = 1'b1;
        tick(4);
        bus_write(4'd1, 8'h03);
        push("status_clear_irq", 0); pop_check(irq);

        // Background colour stage.
        bus_write(4'd10, 8'hA5);
        bg_sel   = 2'd2;
        _char_bg = 1'b0;
        tick();
        push("bg_dcol", 8'hA5); pop_check(dcol);
        push("bg_dcol_oe", 1);  pop_check(dcol_oe);
        bus.addr    = 4'd10;
        bus.data_in = 8'h3C;
        bus._vga_io = 1'b0;
        bus._wr     = 1'b0;
        push("bg_wr_edge_old", 8'hA5);
        push("bg_wr_next_new", 8'h3C);
        tick();
        pop_check(dcol);
        bus._vga_io = 1'b1;
        bus._wr     = 1'b1;
        tick();
        pop_check(dcol);
        _char_bg = 1'b1;
        tick();
        push("bg_off_dcol", 0); pop_check(dcol);
        push("bg_off_oe", 0);   pop_check(dcol_oe);
        bus_write(4'd11, 8'h81);
        bg_sel   = 2'd3;
        _char_bg = 1'b0;
        tick();
        push("bg3_dcol", 8'h81); pop_check(dcol);
        _char_bg = 1'b1;
        bus_read(4'd10, "bg2_read", 8'h3C);

`ifdef VGA_LINE_IRQ_EN
        // Line compare at 5 with only ln_en set.
        bus_write(4'd2, 8'h05);
        bus_write(4'd3, 8'hFF);
        bus_read(4'd3, "lcmp_hi_width", 8'h03);
        bus_write(4'd3, 8'h00);
        bus_write(4'd0, 8'h10);
        vsync = 1'b0;
        tick(4);
        vsync = 1'b1;
        tick(4);
        bus_write(4'd1, 8'h03);
        bus_read(4'd4, "lcnt_after_vs", 0);
        repeat (4) hs_pulse();
        bus_read(4'd4, "lcnt_4", 4);
        push("ln_irq_early", 0); pop_check(irq);
        hs_pulse();
        bus_read(4'd4, "lcnt_5", 5);
        push("ln_irq", 1); pop_check(irq);
        bus_read(4'd1, "ln_status", 8'h02);

        // vs_fall and hs_fall together: clear wins.
        vsync = 1'b0;
        hsync = 1'b0;
        tick(3);
        hsync = 1'b1;
        tick(3);
        vsync = 1'b1;
        tick(4);
        bus_read(4'd4, "lcnt_vs_hs_same", 0);

        // Saturation after 1100 lines.
        exp_cnt = 0;
        for (int i = 0; i < 1100; i++) begin
            hs_pulse();
            if (exp_cnt < (2 ** LINE_W) - 1)
                exp_cnt++;
        end
        bus_read(4'd4, "lcnt_sat_lo", exp_cnt & 8'hFF);
        bus_read(4'd5, "lcnt_sat_hi", exp_cnt >> 8);
`else
        // Line feature absent: registers read 0, hsync never raises irq.
        exp_cnt = 0;
        bus_write(4'd2, 8'h77);
        bus_read(4'd2, "nolin_lcmp", exp_cnt);
        bus_read(4'd4, "nolin_lcnt", exp_cnt);
        bus_write(4'd0, 8'h18);
        bus_write(4'd1, 8'h03);
        repeat (6) hs_pulse();
        push("nolin_irq", 0); pop_check(irq);
        bus_read(4'd1, "nolin_status", 0);
        bus_read(4'd0, "nolin_ctrl", 8'h68);
`endif

        check("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
